// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/LSU arbiter for the single cache data port
// LSU has priority; starve_q bounds consecutive LSU wins while fetch waits.
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [2:0]  ls_mode,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_gnt,
  output logic        ls_done,
  output logic        ls_err,
  output logic [31:0] ls_rdata,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write,
  output logic        mem_is_read,
  output logic        mem_is_write,
  output logic [2:0]  mem_mode,
  input  logic [31:0] mem_read
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [1:0]  state_q, state_d;
  logic        owner_if_q, owner_if_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  mode_q, mode_d;
  logic        we_q, we_d;
  logic        illegal_q, illegal_d;
  logic [3:0]  starve_q, starve_d;

  logic arb, pick_if, pick_ls, ls_illegal;

  always_comb begin
    arb     = (state_q == S_IDLE) || (state_q == S_RESP);
    pick_if = arb && if_req && (!ls_req || (starve_q == STARVE_LIM));
    pick_ls = arb && ls_req && !pick_if;
    // stores only support B/H/W; loads additionally allow BU/HU
    if (ls_we) ls_illegal = ls_mode[2] || (ls_mode == 3'b011);
    else       ls_illegal = (ls_mode == 3'b011) || (ls_mode[2:1] == 2'b11);
  end

  always_comb begin
    state_d    = state_q;
    owner_if_d = owner_if_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    mode_d     = mode_q;
    we_d       = we_q;
    illegal_d  = illegal_q;
    starve_d   = starve_q;
    if (pick_if) begin
      state_d    = S_ISSUE;
      owner_if_d = 1'b1;
      addr_d     = if_addr;
      wdata_d    = 32'h0;
      mode_d     = 3'b010;
      we_d       = 1'b0;
      illegal_d  = 1'b0;
    end else if (pick_ls) begin
      state_d    = S_ISSUE;
      owner_if_d = 1'b0;
      addr_d     = ls_addr;
      wdata_d    = ls_wdata;
      mode_d     = ls_mode;
      we_d       = ls_we;
      illegal_d  = ls_illegal;
    end else if (arb) begin
      state_d = S_IDLE;
    end else begin
      state_d = S_RESP;
    end
    if (arb) begin
      if (!if_req || pick_if) starve_d = 4'd0;
      else if (pick_ls && (starve_q < STARVE_LIM)) starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      owner_if_q <= 1'b0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      mode_q     <= 3'b000;
      we_q       <= 1'b0;
      illegal_q  <= 1'b0;
      starve_q   <= 4'd0;
    end else begin
      state_q    <= state_d;
      owner_if_q <= owner_if_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      mode_q     <= mode_d;
      we_q       <= we_d;
      illegal_q  <= illegal_d;
      starve_q   <= starve_d;
    end
  end

  always_comb begin
    mem_address  = addr_q;
    mem_write    = wdata_q;
    mem_mode     = mode_q;
    mem_is_read  = (state_q == S_ISSUE) && !illegal_q && !we_q;
    mem_is_write = (state_q == S_ISSUE) && !illegal_q && we_q;
    if_gnt       = (state_q == S_ISSUE) && owner_if_q;
    ls_gnt       = (state_q == S_ISSUE) && !owner_if_q;
    if_rvalid    = (state_q == S_RESP) && owner_if_q;
    ls_done      = (state_q == S_RESP) && !owner_if_q;
    ls_err       = ls_done && illegal_q;
    if_rdata     = if_rvalid ? mem_read : 32'h0;
    ls_rdata     = (ls_done && !we_q && !illegal_q) ? mem_read : 32'h0;
  end

endmodule
